// File: rtl/dmem_responder.sv
// Memory-side responder for the dCPU bus: a 256x8 RAM behind a LOAD/RUN/DUMP/DONE
// run-control FSM that streams a program in, runs the CPU, then streams memory out.
module dmem_responder #(
  parameter int          DUMP_LEN = 256,
  parameter int          CNT_W    = 16,
  parameter logic [7:0]  FILL     = 8'h90
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cpu_addr,
  input  logic             cpu_R,
  input  logic             cpu_W,
  input  logic [7:0]       cpu_wdata,
  input  logic             cpu_stop,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_rst,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             dump_valid,
  output logic [7:0]       dump_data,
  output logic             dump_last,
  input  logic             dump_ready,
  input  logic             restart,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             bus_err
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] DUMP_END = 8'(DUMP_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] mem [256];
  logic [7:0] lptr, lptr_nxt;
  logic [7:0] dptr, dptr_nxt;
  logic       armed;
  logic       rd_act, wr_act;
  logic       load_we, cpu_we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // CPU strobe decode: only meaningful while the CPU is running
  always_comb begin
    rd_act  = (state == S_RUN) && !cpu_R;
    wr_act  = (state == S_RUN) && !cpu_W;
    cpu_we  = wr_act && cpu_R;
    load_we = (state == S_LOAD) && armed && load_valid;
  end

  // Zero-wait reads: the CPU samples cpu_rdata at the edge closing its R-low cycle
  always_comb begin
    cpu_rdata = rd_act ? mem[cpu_addr] : FILL;
    dump_data = mem[dptr];
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[lptr] <= load_data;
    end else if (cpu_we) begin
      mem[cpu_addr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      lptr  <= '0;
      dptr  <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      lptr  <= lptr_nxt;
      dptr  <= dptr_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    lptr_nxt   = lptr;
    dptr_nxt   = dptr;
    cpu_rst    = 1'b1;
    load_ready = 1'b0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    case (state)
      S_LOAD: begin
        // armed keeps load_ready low for the first cycle out of reset
        load_ready = armed;
        if (load_we) begin
          lptr_nxt = lptr + 8'd1;
          if (load_last || (lptr == 8'hFF)) begin
            state_nxt = S_RUN;
            lptr_nxt  = '0;
          end
        end
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        if (cpu_stop) begin
          state_nxt = S_DUMP;
        end
      end
      S_DUMP: begin
        dump_valid = 1'b1;
        dump_last  = (dptr == DUMP_END);
        if (dump_ready) begin
          if (dptr == DUMP_END) begin
            state_nxt = S_DONE;
            dptr_nxt  = '0;
          end else begin
            dptr_nxt = dptr + 8'd1;
          end
        end
      end
      S_DONE: begin
        if (restart) begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Access statistics survive restart; only rst_n clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (rd_act && !wr_act) begin
        rd_count <= sat_inc(rd_count);
      end
      if (wr_act && !rd_act) begin
        wr_count <= sat_inc(wr_count);
      end
      if (rd_act && wr_act) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: load, run-time access, bus conflict, stalled dump,
// restart, full 256-byte load, reset mid-dump and counter saturation.
module tb_dmem_responder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [7:0]       cpu_addr;
  logic             cpu_R;
  logic             cpu_W;
  logic [7:0]       cpu_wdata;
  logic             cpu_stop;
  logic [7:0]       cpu_rdata;
  logic             cpu_rst;
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_last;
  logic             load_ready;
  logic             dump_valid;
  logic [7:0]       dump_data;
  logic             dump_last;
  logic             dump_ready;
  logic             restart;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
  logic             bus_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] lbytes [3] = '{8'hC0, 8'h05, 8'hCC};
  logic [7:0] dexp   [4] = '{8'hC0, 8'h05, 8'hCC, 8'h5A};
  logic       rdy    [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  dmem_responder #(.DUMP_LEN(4), .CNT_W(CNT_W), .FILL(8'h90)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_R(cpu_R), .cpu_W(cpu_W), .cpu_wdata(cpu_wdata),
    .cpu_stop(cpu_stop), .cpu_rdata(cpu_rdata), .cpu_rst(cpu_rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
    .dump_ready(dump_ready),
    .restart(restart), .rd_count(rd_count), .wr_count(wr_count), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_R = 1'b1; cpu_W = 1'b1; cpu_wdata = '0;
    cpu_stop = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    dump_ready = 1'b0; restart = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_last", dump_last, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rdata_fill", cpu_rdata, 8'h90);
    rst_n = 1'b1;
    #1 chk("first_cycle_load_ready", load_ready, 0);
    tick();
    chk("load_ready_up", load_ready, 1);
    chk("load_cpu_rst", cpu_rst, 1);

    // three-byte load ending with load_last
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = lbytes[i]; load_last = (i == 2);
      tick();
      if (i < 2) chk("still_load", cpu_rst, 1);
    end
    load_valid = 1'b0; load_last = 1'b0;
    #1 chk("run_cpu_rst", cpu_rst, 0);
    chk("run_load_ready", load_ready, 0);
    cpu_R = 1'b0; cpu_addr = 8'd0;
    #1 chk("rd_mem0", cpu_rdata, 8'hC0);
    cpu_addr = 8'd1;
    #1 chk("rd_mem1", cpu_rdata, 8'h05);
    cpu_addr = 8'd2;
    #1 chk("rd_mem2", cpu_rdata, 8'hCC);
    cpu_R = 1'b1;
    #1 chk("rdata_idle_fill", cpu_rdata, 8'h90);
    tick();

    // write then read back at addr 10
    cpu_addr = 8'd10; cpu_wdata = 8'h3A; cpu_W = 1'b0;
    tick();
    cpu_W = 1'b1;
    chk("wr_count_1", wr_count, 1);
    chk("rd_count_0", rd_count, 0);
    cpu_R = 1'b0;
    #1 chk("rd_back_3A", cpu_rdata, 8'h3A);
    tick();
    cpu_R = 1'b1;
    chk("rd_count_1", rd_count, 1);

    cpu_addr = 8'd4; cpu_wdata = 8'h11; cpu_W = 1'b0;
    tick();
    cpu_addr = 8'd3; cpu_wdata = 8'h5A;
    tick();
    cpu_W = 1'b1;
    chk("wr_count_3", wr_count, 3);

    // restart is ignored while running
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_ignored_run", cpu_rst, 0);

    // both strobes low: read served, write suppressed, bus_err
    cpu_addr = 8'd4; cpu_wdata = 8'hFF; cpu_R = 1'b0; cpu_W = 1'b0;
    #1 chk("conflict_rdata", cpu_rdata, 8'h11);
    tick();
    cpu_R = 1'b1; cpu_W = 1'b1;
    chk("bus_err_set", bus_err, 1);
    chk("conflict_rd_count", rd_count, 1);
    chk("conflict_wr_count", wr_count, 3);
    cpu_R = 1'b0;
    #1 chk("mem4_kept", cpu_rdata, 8'h11);
    cpu_R = 1'b1;
    tick();

    // stop and stalled dump
    cpu_stop = 1'b1;
    tick();
    cpu_stop = 1'b0;
    chk("dump_cpu_rst", cpu_rst, 1);
    begin
      int idx;
      idx = 0;
      for (int k = 0; k < 5; k++) begin
        dump_ready = rdy[k];
        #1;
        chk("dump_valid", dump_valid, 1);
        chk("dump_data", dump_data, dexp[idx]);
        chk("dump_last", dump_last, (idx == 3) ? 1 : 0);
        tick();
        if (rdy[k]) idx++;
      end
    end
    dump_ready = 1'b0;
    chk("done_dump_valid", dump_valid, 0);
    chk("done_dump_last", dump_last, 0);
    chk("done_cpu_rst", cpu_rst, 1);
    chk("done_load_ready", load_ready, 0);

    // strobes ignored in DONE
    cpu_addr = 8'd0; cpu_R = 1'b0;
    #1 chk("done_rdata_fill", cpu_rdata, 8'h90);
    cpu_R = 1'b1; cpu_W = 1'b0; cpu_wdata = 8'hEE;
    tick();
    cpu_W = 1'b1;
    chk("done_wr_count", wr_count, 3);
    chk("done_rd_count", rd_count, 1);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_load_ready", load_ready, 1);
    chk("restart_bus_err_kept", bus_err, 1);
    chk("restart_wr_kept", wr_count, 3);

    // full 256-byte load without load_last
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = 8'(i) ^ 8'hA5; load_last = 1'b0;
      if (i == 255) begin
        #1 chk("pre_last_load_ready", load_ready, 1);
      end
      tick();
    end
    load_valid = 1'b0;
    #1 chk("full_load_ready", load_ready, 0);
    chk("full_cpu_rst", cpu_rst, 0);
    cpu_R = 1'b0; cpu_addr = 8'd0;
    #1 chk("full_mem0", cpu_rdata, 8'hA5);
    cpu_addr = 8'd10;
    #1 chk("full_mem10", cpu_rdata, 8'hAF);
    cpu_addr = 8'hFF;
    #1 chk("full_mem255", cpu_rdata, 8'h5A);
    cpu_R = 1'b1;
    tick();

    // reset asserted mid-dump at dptr=2
    cpu_stop = 1'b1;
    tick();
    cpu_stop = 1'b0; dump_ready = 1'b1;
    tick(); tick();
    dump_ready = 1'b0;
    #1 chk("mid_dump_data", dump_data, 8'hA7);
    rst_n = 1'b0;
    #1;
    chk("abort_dump_valid", dump_valid, 0);
    chk("abort_dump_last", dump_last, 0);
    chk("abort_cpu_rst", cpu_rst, 1);
    chk("abort_load_ready", load_ready, 0);
    chk("abort_rd_count", rd_count, 0);
    chk("abort_wr_count", wr_count, 0);
    chk("abort_bus_err", bus_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("reload_ready", load_ready, 1);
    load_valid = 1'b1; load_data = 8'h77; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    #1 chk("reload_run", cpu_rst, 0);
    cpu_R = 1'b0; cpu_addr = 8'd0;
    #1 chk("reload_mem0", cpu_rdata, 8'h77);
    cpu_addr = 8'd1;
    #1 chk("ram_intact_mem1", cpu_rdata, 8'hA4);
    cpu_addr = 8'd2;
    #1 chk("ram_intact_mem2", cpu_rdata, 8'hA7);

    // read counter saturation (4-bit counter, 20 reads)
    repeat (20) tick();
    cpu_R = 1'b1;
    chk("rd_count_sat", rd_count, 15);
    chk("wr_count_zero", wr_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
